// File: rtl/fb_write_scheduler.sv
// Framebuffer write scheduler: during blanking, pops pixels from a FIFO and
// read-modify-writes the matching cell bit in the three packed colour planes.
`timescale 1ns/1ps
module fb_write_scheduler #(
   parameter int X_WIRE_WIDTH = 10,
   parameter int Y_WIRE_WIDTH = 10,
   parameter int DATA_WIDTH   = 6,
   parameter int ADDR_WIDTH   = 10,
   parameter int CELL_SHIFT   = 3,
   parameter int CELLS_H      = 80,
   parameter int CELLS_V      = 60
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    display_on,
   input  logic                    fifo_empty,
   output logic                    fifo_pop,
   input  logic [X_WIRE_WIDTH-1:0] fifo_hpos,
   input  logic [Y_WIRE_WIDTH-1:0] fifo_vpos,
   input  logic [2:0]              fifo_rgb,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic                    mem_rd_en,
   input  logic [DATA_WIDTH-1:0]   mem_rd_r,
   input  logic [DATA_WIDTH-1:0]   mem_rd_g,
   input  logic [DATA_WIDTH-1:0]   mem_rd_b,
   output logic                    mem_we,
   output logic [DATA_WIDTH-1:0]   mem_wr_r,
   output logic [DATA_WIDTH-1:0]   mem_wr_g,
   output logic [DATA_WIDTH-1:0]   mem_wr_b,
   output logic                    busy,
   output logic [15:0]             drop_cnt
);

   localparam int          BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [31:0] CELLS_H_U  = CELLS_H;
   localparam logic [31:0] CELLS_V_U  = CELLS_V;
   localparam logic [31:0] DATA_W_U   = DATA_WIDTH;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      CALC,
      READ,
      MODIFY,
      WRITE
   } state_t;

   state_t                 state;
   logic [BIT_W-1:0]       bit_pos;
   logic [2:0]             rgb_q;
   logic [15:0]            drop_q;

   logic [31:0]            cx;
   logic [31:0]            cy;
   logic [31:0]            idx;
   logic [31:0]            word;
   logic [31:0]            rem;
   logic                   in_range;
   logic [DATA_WIDTH-1:0]  mask;

   // Cell index and packed-word position of the pixel presented during CALC.
   always_comb begin
      cx       = 32'(fifo_hpos) >> CELL_SHIFT;
      cy       = 32'(fifo_vpos) >> CELL_SHIFT;
      idx      = cy * CELLS_H_U + cx;
      word     = idx / DATA_W_U;
      rem      = idx - word * DATA_W_U;
      in_range = (cx < CELLS_H_U) && (cy < CELLS_V_U);
      mask     = DATA_WIDTH'(1) << bit_pos;
   end

   // NOTE: the memory strobes are decoded from the registered state and gated
   // by display_on in the same cycle, so the display can never be disturbed
   // even if it reclaims the port without warning.
   assign mem_rd_en = (state == READ)  && !display_on;
   assign mem_we    = (state == WRITE) && !display_on;
   assign busy      = (state != IDLE);
   assign drop_cnt  = drop_q;

   // NOTE: all state below is updated with non-blocking assignments so every
   // branch sees the values from the start of the cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         fifo_pop <= 1'b0;
         mem_addr <= '0;
         bit_pos  <= '0;
         rgb_q    <= '0;
         mem_wr_r <= '0;
         mem_wr_g <= '0;
         mem_wr_b <= '0;
         drop_q   <= '0;
      end else begin
         fifo_pop <= 1'b0;
         case (state)
            IDLE: begin
               if (!display_on && !fifo_empty) begin
                  state    <= POP;
                  fifo_pop <= 1'b1;
               end
            end
            POP: begin
               state <= CALC;
            end
            CALC: begin
               rgb_q <= fifo_rgb;
               if (in_range) begin
                  mem_addr <= ADDR_WIDTH'(word);
                  bit_pos  <= BIT_W'(rem);
                  state    <= READ;
               end else begin
                  if (drop_q != 16'hFFFF) begin
                     drop_q <= drop_q + 16'd1;
                  end
                  state <= IDLE;
               end
            end
            READ: begin
               if (!display_on) begin
                  state <= MODIFY;
               end
            end
            MODIFY: begin
               mem_wr_r <= rgb_q[2] ? (mem_rd_r | mask) : (mem_rd_r & ~mask);
               mem_wr_g <= rgb_q[1] ? (mem_rd_g | mask) : (mem_rd_g & ~mask);
               mem_wr_b <= rgb_q[0] ? (mem_rd_b | mask) : (mem_rd_b & ~mask);
               state    <= WRITE;
            end
            WRITE: begin
               // The modified words stay put until the display releases the port.
               if (!display_on) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler: FIFO and framebuffer models plus
// hand-computed addresses, bit positions and read-modify-write results.
`timescale 1ns/1ps
module tb_fb_write_scheduler;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        display_on;
   logic        fifo_empty;
   logic        fifo_pop;
   logic [9:0]  fifo_hpos;
   logic [9:0]  fifo_vpos;
   logic [2:0]  fifo_rgb;
   logic [9:0]  mem_addr;
   logic        mem_rd_en;
   logic [5:0]  mem_rd_r;
   logic [5:0]  mem_rd_g;
   logic [5:0]  mem_rd_b;
   logic        mem_we;
   logic [5:0]  mem_wr_r;
   logic [5:0]  mem_wr_g;
   logic [5:0]  mem_wr_b;
   logic        busy;
   logic [15:0] drop_cnt;

   fb_write_scheduler dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .display_on (display_on),
      .fifo_empty (fifo_empty),
      .fifo_pop   (fifo_pop),
      .fifo_hpos  (fifo_hpos),
      .fifo_vpos  (fifo_vpos),
      .fifo_rgb   (fifo_rgb),
      .mem_addr   (mem_addr),
      .mem_rd_en  (mem_rd_en),
      .mem_rd_r   (mem_rd_r),
      .mem_rd_g   (mem_rd_g),
      .mem_rd_b   (mem_rd_b),
      .mem_we     (mem_we),
      .mem_wr_r   (mem_wr_r),
      .mem_wr_g   (mem_wr_g),
      .mem_wr_b   (mem_wr_b),
      .busy       (busy),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   // FIFO contents {hpos, vpos, rgb}; written by the stimulus, drained by the model.
   logic [22:0] ent [0:15];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   assign fifo_empty = (rd_ptr == wr_ptr);

   // Framebuffer planes {R, G, B}; preloaded once, writes are only recorded.
   logic [17:0] mem [0:1023];

   int          cyc = 0;
   int          pop_cnt = 0;
   int          rd_cnt = 0;
   int          we_cnt = 0;
   int          viol = 0;
   int          pop_cyc [0:63];
   int          last_we_cyc = 0;
   logic [9:0]  last_rd_addr = '0;
   logic [9:0]  last_we_addr = '0;
   logic [5:0]  last_we_r = '0;
   logic [5:0]  last_we_g = '0;
   logic [5:0]  last_we_b = '0;

   // Monitor on the falling edge, then FIFO/memory responses just after the rising edge.
   always begin : model
      logic       pop_now;
      logic       rd_now;
      logic [9:0] rd_addr;
      @(negedge clk);
      cyc++;
      pop_now = fifo_pop;
      rd_now  = mem_rd_en;
      rd_addr = mem_addr;
      if (int'(fifo_pop) + int'(mem_rd_en) + int'(mem_we) > 1) viol++;
      if (display_on && (mem_rd_en || mem_we)) viol++;
      if (fifo_pop) begin
         if (pop_cnt < 64) pop_cyc[pop_cnt] = cyc;
         pop_cnt++;
      end
      if (mem_rd_en) begin
         rd_cnt++;
         last_rd_addr = mem_addr;
      end
      if (mem_we) begin
         we_cnt++;
         last_we_cyc  = cyc;
         last_we_addr = mem_addr;
         last_we_r    = mem_wr_r;
         last_we_g    = mem_wr_g;
         last_we_b    = mem_wr_b;
      end
      @(posedge clk);
      #1;
      if (pop_now && (rd_ptr < wr_ptr)) begin
         {fifo_hpos, fifo_vpos, fifo_rgb} = ent[rd_ptr];
         rd_ptr++;
      end else begin
         fifo_hpos = 10'($urandom);
         fifo_vpos = 10'($urandom);
         fifo_rgb  = 3'($urandom);
      end
      if (rd_now) begin
         {mem_rd_r, mem_rd_g, mem_rd_b} = mem[rd_addr];
      end else begin
         {mem_rd_r, mem_rd_g, mem_rd_b} = 18'($urandom);
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push(input logic [9:0] h, input logic [9:0] v, input logic [2:0] c);
      ent[wr_ptr] = {h, v, c};
      wr_ptr++;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      step();
      while (!(fifo_empty && !busy) && n < 200) begin
         step();
         n++;
      end
      check({tag, "_drained"}, 32'(fifo_empty && !busy), 1);
   endtask

   task automatic wait_rd(input string tag);
      int n = 0;
      while (!mem_rd_en && n < 50) begin
         step();
         n++;
      end
      check({tag, "_read_seen"}, 32'(mem_rd_en), 1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int b_pop;
      int b_rd;
      int b_we;
      int rel_cyc;

      reset_n    = 1'b0;
      display_on = 1'b1;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      mem[799] = {6'b001010, 6'b000101, 6'b011111};
      mem[0]   = {6'b111111, 6'b000000, 6'b101010};

      step(3);
      check("rst_pop",     32'(fifo_pop), 0);
      check("rst_rd_en",   32'(mem_rd_en), 0);
      check("rst_we",      32'(mem_we), 0);
      check("rst_busy",    32'(busy), 0);
      check("rst_addr",    32'(mem_addr), 0);
      check("rst_wr_r",    32'(mem_wr_r), 0);
      check("rst_drop",    32'(drop_cnt), 0);
      reset_n = 1'b1;
      step(2);

      // Single entry (17,9) rgb 101: idx 82 -> addr 13, bit 4.
      display_on = 1'b0;
      b_pop = pop_cnt; b_rd = rd_cnt; b_we = we_cnt;
      push(10'd17, 10'd9, 3'b101);
      drain("s1");
      check("s1_reads",     32'(rd_cnt - b_rd), 1);
      check("s1_rd_addr",   32'(last_rd_addr), 13);
      check("s1_writes",    32'(we_cnt - b_we), 1);
      check("s1_wr_addr",   32'(last_we_addr), 13);
      check("s1_wr_r",      32'(last_we_r), 32'b010000);
      check("s1_wr_g",      32'(last_we_g), 0);
      check("s1_wr_b",      32'(last_we_b), 32'b010000);
      check("s1_pop_to_we", 32'(last_we_cyc - pop_cyc[b_pop]), 4);

      // Last cell (639,479) rgb 111: idx 4799 -> addr 799, bit 5.
      push(10'd639, 10'd479, 3'b111);
      drain("s2");
      check("s2_wr_addr", 32'(last_we_addr), 799);
      check("s2_wr_r",    32'(last_we_r), 32'b101010);
      check("s2_wr_g",    32'(last_we_g), 32'b100101);
      check("s2_wr_b",    32'(last_we_b), 32'b111111);

      // Out-of-range entries are discarded and counted, saturating.
      b_rd = rd_cnt; b_we = we_cnt;
      push(10'd700, 10'd0, 3'b001);
      drain("s3a");
      check("s3_drop_one", 32'(drop_cnt), 1);
      dut.drop_q = 16'hFFFE;
      push(10'd700, 10'd0, 3'b001);
      drain("s3b");
      check("s3_drop_sat", 32'(drop_cnt), 32'hFFFF);
      push(10'd0, 10'd480, 3'b111);
      drain("s3c");
      check("s3_drop_hold", 32'(drop_cnt), 32'hFFFF);
      check("s3_no_reads",  32'(rd_cnt - b_rd), 0);
      check("s3_no_writes", 32'(we_cnt - b_we), 0);

      // Display reclaims the port during MODIFY: (8,0) rgb 010 -> addr 0, bit 1.
      b_we = we_cnt;
      push(10'd8, 10'd0, 3'b010);
      wait_rd("s4");
      step();
      display_on = 1'b1;
      step(5);
      check("s4_held_no_we", 32'(we_cnt - b_we), 0);
      check("s4_held_busy",  32'(busy), 1);
      check("s4_held_wr_r",  32'(mem_wr_r), 32'b111101);
      check("s4_held_wr_g",  32'(mem_wr_g), 32'b000010);
      check("s4_held_wr_b",  32'(mem_wr_b), 32'b101000);
      display_on = 1'b0;
      drain("s4");
      check("s4_one_write", 32'(we_cnt - b_we), 1);
      check("s4_wr_addr",   32'(last_we_addr), 0);
      check("s4_wr_r",      32'(last_we_r), 32'b111101);
      check("s4_wr_g",      32'(last_we_g), 32'b000010);
      check("s4_wr_b",      32'(last_we_b), 32'b101000);

      // Three queued entries; no pops while the display is on, then 6-cycle spacing.
      display_on = 1'b1;
      b_pop = pop_cnt; b_we = we_cnt;
      push(10'd0,   10'd0,   3'b100);
      push(10'd47,  10'd8,   3'b001);
      push(10'd100, 10'd200, 3'b011);
      step(4);
      check("s5_no_pop_on", 32'(pop_cnt - b_pop), 0);
      check("s5_idle_on",   32'(busy), 0);
      display_on = 1'b0;
      drain("s5");
      check("s5_pops",    32'(pop_cnt - b_pop), 3);
      check("s5_writes",  32'(we_cnt - b_we), 3);
      check("s5_gap_1",   32'(pop_cyc[b_pop + 1] - pop_cyc[b_pop]), 6);
      check("s5_gap_2",   32'(pop_cyc[b_pop + 2] - pop_cyc[b_pop + 1]), 6);
      check("s5_wr_addr", 32'(last_we_addr), 335);
      check("s5_wr_r",    32'(last_we_r), 0);
      check("s5_wr_g",    32'(last_we_g), 32'b000100);
      check("s5_wr_b",    32'(last_we_b), 32'b000100);

      // Reset during READ: first entry lost, second (16,0) rgb 110 -> addr 0, bit 2.
      push(10'd24, 10'd16, 3'b111);
      push(10'd16, 10'd0,  3'b110);
      wait_rd("s6");
      reset_n = 1'b0;
      #1;
      check("s6_rst_pop",   32'(fifo_pop), 0);
      check("s6_rst_rd_en", 32'(mem_rd_en), 0);
      check("s6_rst_we",    32'(mem_we), 0);
      check("s6_rst_busy",  32'(busy), 0);
      check("s6_rst_addr",  32'(mem_addr), 0);
      check("s6_rst_wr_g",  32'(mem_wr_g), 0);
      check("s6_rst_wr_b",  32'(mem_wr_b), 0);
      check("s6_rst_drop",  32'(drop_cnt), 0);
      step(2);
      b_pop = pop_cnt; b_rd = rd_cnt; b_we = we_cnt;
      reset_n = 1'b1;
      rel_cyc = cyc;
      drain("s6");
      check("s6_pops",      32'(pop_cnt - b_pop), 1);
      check("s6_pop_delay", 32'((pop_cyc[b_pop] - rel_cyc) >= 2), 1);
      check("s6_reads",     32'(rd_cnt - b_rd), 1);
      check("s6_writes",    32'(we_cnt - b_we), 1);
      check("s6_wr_addr",   32'(last_we_addr), 0);
      check("s6_wr_r",      32'(last_we_r), 32'b111111);
      check("s6_wr_g",      32'(last_we_g), 32'b000100);
      check("s6_wr_b",      32'(last_we_b), 32'b101010);

      check("strobe_rules", 32'(viol), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fb_write_scheduler.md
FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

Interface
REQ-001 Parameters (name, default, meaning):
- X_WIRE_WIDTH, 10, hpos width
- Y_WIRE_WIDTH, 10, vpos width
- DATA_WIDTH, 6, cells packed per framebuffer word, per colour plane
- ADDR_WIDTH, 10, framebuffer word address width
- CELL_SHIFT, 3, log2 of cell edge in pixels (8x8 cells)
- CELLS_H, 80, cells per row
- CELLS_V, 60, cell rows
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock
- reset_n, in, 1, reset; asynchronous, active-low
- display_on, in, 1, 1 = display owns framebuffer port; 0 = blanking, scheduler may access it
- fifo_empty, in, 1, pixel FIFO empty
- fifo_pop, out, 1, one-cycle pop strobe to pixel FIFO
- fifo_hpos, in, X_WIRE_WIDTH, popped pixel x
- fifo_vpos, in, Y_WIRE_WIDTH, popped pixel y
- fifo_rgb, in, 3, popped pixel colour {R,G,B}
- mem_addr, out, ADDR_WIDTH, framebuffer word address
- mem_rd_en, out, 1, read strobe; data valid next cycle
- mem_rd_r / mem_rd_g / mem_rd_b, in, DATA_WIDTH each, read data per plane
- mem_we, out, 1, write strobe
- mem_wr_r / mem_wr_g / mem_wr_b, out, DATA_WIDTH each, write data per plane
- busy, out, 1, high in any state other than IDLE
- drop_cnt, out, 16, saturating count of discarded out-of-range entries

Function
REQ-003 The FSM SHALL have the states IDLE, POP, CALC, READ, MODIFY and WRITE, and SHALL be one-hot or binary-encoded with no other reachable state.
REQ-004 IDLE->POP SHALL occur when display_on=0 and fifo_empty=0; fifo_pop SHALL be high for exactly the one cycle spent in POP.
REQ-005 FIFO data SHALL be valid in the cycle after POP; CALC SHALL register fifo_hpos, fifo_vpos and fifo_rgb in that cycle.
REQ-006 CALC SHALL compute cx=hpos>>CELL_SHIFT, cy=vpos>>CELL_SHIFT and idx=cy*CELLS_H+cx.
REQ-007 CALC SHALL compute addr=idx/DATA_WIDTH and bit=idx-addr*DATA_WIDTH exactly, for every idx<CELLS_H*CELLS_V; the reciprocal multiply (idx*10923)>>16 is acceptable.
REQ-008 If cx>=CELLS_H or cy>=CELLS_V, the entry SHALL be discarded: CALC->IDLE, no memory access, and drop_cnt SHALL increment, saturating at 16'hFFFF.
REQ-009 READ SHALL assert mem_rd_en=1 with mem_addr=addr for one cycle only while display_on=0; while display_on=1 the FSM SHALL hold in READ with all strobes low.
REQ-010 MODIFY SHALL capture mem_rd_r/g/b and replace bit position `bit` of each plane with the corresponding fifo_rgb bit, leaving the other bits unchanged.
REQ-011 WRITE SHALL assert mem_we=1, mem_addr=addr and mem_wr_*=modified words for one cycle only while display_on=0, then go to IDLE; while display_on=1 it SHALL hold in WRITE with the modified data retained.
REQ-012 If display_on rises between READ and WRITE, the write SHALL be deferred and not repeated, and the stored read data SHALL stay valid.
REQ-013 At most one strobe among fifo_pop, mem_rd_en and mem_we SHALL be high in any cycle.
REQ-014 mem_rd_en and mem_we SHALL never be high while display_on=1.
REQ-015 Best-case throughput SHALL be one entry per 6 cycles: IDLE, POP, CALC, READ, MODIFY, WRITE.
REQ-016 A new pop SHALL NOT occur before the WRITE of the previous entry completes.
REQ-017 fifo_empty SHALL be sampled only in IDLE.

Reset
REQ-018 While reset_n=0, the state SHALL be IDLE and fifo_pop, mem_rd_en, mem_we and busy SHALL be 0.
REQ-019 While reset_n=0, mem_addr, mem_wr_r, mem_wr_g, mem_wr_b and drop_cnt SHALL be 0.
REQ-020 Reset asserted mid-transaction SHALL abandon the entry with no further pop, read or write; the first pop after release SHALL take at least 1 cycle.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- display_on=0; one entry (hpos=17, vpos=9, rgb=3'b101); memory returns R=G=B=6'b000000 -> idx=82, addr=13, bit=4; write R=6'b010000, G=0, B=6'b010000; fifo_pop to mem_we spacing is exactly 4 cycles.
- Entry (hpos=639, vpos=479), rgb=3'b111 -> idx=4799, addr=799, bit=5; bit 5 set in all planes, other bits preserved from the read data.
- Entry (hpos=700, vpos=0) -> no mem_rd_en or mem_we, drop_cnt 0->1; with drop_cnt preloaded near saturation, it holds at 16'hFFFF.
- display_on rises during MODIFY -> FSM holds in WRITE, mem_we stays low; display_on falls -> exactly one mem_we with the correct data.
- Three queued entries under continuous blanking -> pops spaced 6 cycles apart; fifo_pop, mem_rd_en and mem_we never overlap.
- reset_n pulsed low in READ -> all outputs 0 immediately; after release the entry is lost and the next FIFO entry is processed normally.
